// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM (fetch/decode/exec/mem/wb).
// Ports: clock, reset_n, opcode, zero, mem_ready -> datapath strobes/selects,
// illegal_op pulse, debug state, retired-instruction counter.
module multicycle_control #(
   parameter int RETIRE_W = 32
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [5:0]          opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_source,
   output logic                illegal_op,
   output logic [3:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_CMPL    = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t               state_q, state_d;
   logic [RETIRE_W-1:0]  retired_q;
   logic                 illegal_q, illegal_d;
   logic                 retire;

   // branch condition is applied in the datapath, not here
   logic unused_zero;
   assign unused_zero = zero;

   logic is_r, is_mem, is_beq, is_j, is_addi;
   assign is_r    = (opcode == OP_R);
   assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
   assign is_beq  = (opcode == OP_BEQ);
   assign is_j    = (opcode == OP_J);
   assign is_addi = (opcode == OP_ADDI);

   always_comb begin
      state_d   = FETCH;
      illegal_d = 1'b0;
      retire    = 1'b0;
      case (state_q)
         FETCH:     state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            unique case (1'b1)
               is_mem:  state_d = MEM_ADDR;
               is_r:    state_d = EXECUTE;
               is_beq:  state_d = BRANCH;
               is_j:    state_d = JUMP;
               is_addi: state_d = ADDI_EXEC;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEM_ADDR:  state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
         MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
         MEM_WB:    retire  = 1'b1;
         MEM_WRITE: begin
            state_d = mem_ready ? FETCH : MEM_WRITE;
            retire  = mem_ready;
         end
         EXECUTE:   state_d = R_CMPL;
         R_CMPL:    retire  = 1'b1;
         BRANCH:    retire  = 1'b1;
         JUMP:      retire  = 1'b1;
         ADDI_EXEC: state_d = ADDI_WB;
         ADDI_WB:   retire  = 1'b1;
         default:   state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FETCH;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         if (retire) retired_q <= retired_q + 1'b1;
      end
   end

   // every output is held low while reset is asserted
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      if (reset_n) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE:    alu_src_b = 2'b11;
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            R_CMPL: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ADDI_WB:   reg_write = 1'b1;
            default: ;
         endcase
      end
   end

   assign state      = state_q;
   assign retired    = retired_q;
   assign illegal_op = illegal_q & reset_n;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// Directed instruction sequences push per-cycle expectations; a monitor checks.
module tb_multicycle_control;

   localparam logic [5:0] R    = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] J    = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ILL  = 6'b111111;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic        illegal_op;
   logic [3:0]  state;
   logic [31:0] retired;

   multicycle_control #(.RETIRE_W(32)) dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
      .retired(retired)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] ctl;
      logic [31:0] ret;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret = 32'd0;

   wire [16:0] ctl_now = {pc_write, pc_write_cond, i_or_d, mem_read,
                          mem_write, ir_write, mem_to_reg, reg_dst,
                          reg_write, alu_src_a, alu_src_b, alu_op,
                          pc_source, illegal_op};

   function automatic logic [16:0] exp_ctl(input logic [3:0] st,
                                           input logic mr,
                                           input logic ill);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
      logic [1:0] sb, op, ps;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
      sb = 2'b00; op = 2'b00; ps = 2'b00;
      case (st)
         4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
         4'd1:  sb = 2'b11;
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin mrd = 1; iod = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mwr = 1; iod = 1; end
         4'd6:  begin sa = 1; op = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
         4'd9:  begin pw = 1; ps = 2'b10; end
         4'd10: begin sa = 1; sb = 2'b10; end
         4'd11: rw = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, op, ps, ill};
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic [5:0] op, input logic mr, input logic z,
                      input logic [3:0] st, input logic ill, input logic ret);
      exp_t e;
      opcode = op; mem_ready = mr; zero = z;
      e.st = st; e.ctl = exp_ctl(st, mr, ill); e.ret = exp_ret;
      q.push_back(e);
      @(posedge clock); #1;
      if (ret) exp_ret++;
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset_n && q.size() > 0) begin
         e = q.pop_front();
         chk("state", {28'd0, state}, {28'd0, e.st});
         chk("ctl", {15'd0, ctl_now}, {15'd0, e.ctl});
         chk("retired", retired, e.ret);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_ctl", {15'd0, ctl_now}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      // R-type
      cyc(R, 1, 0, 0, 0, 0); cyc(R, 1, 0, 1, 0, 0);
      cyc(R, 1, 0, 6, 0, 0); cyc(R, 1, 0, 7, 0, 1);
      // lw with 3-cycle MEM_READ stall
      cyc(LW, 1, 0, 0, 0, 0); cyc(LW, 1, 0, 1, 0, 0); cyc(LW, 1, 0, 2, 0, 0);
      cyc(LW, 0, 0, 3, 0, 0); cyc(LW, 0, 0, 3, 0, 0); cyc(LW, 0, 0, 3, 0, 0);
      cyc(LW, 1, 0, 3, 0, 0); cyc(LW, 1, 0, 4, 0, 1);
      // sw with 2-cycle FETCH stall and 1-cycle MEM_WRITE stall
      cyc(SW, 0, 0, 0, 0, 0); cyc(SW, 0, 0, 0, 0, 0); cyc(SW, 1, 0, 0, 0, 0);
      cyc(SW, 1, 0, 1, 0, 0); cyc(SW, 1, 0, 2, 0, 0);
      cyc(SW, 0, 0, 5, 0, 0); cyc(SW, 1, 0, 5, 0, 1);
      // beq then j
      cyc(BEQ, 1, 1, 0, 0, 0); cyc(BEQ, 1, 1, 1, 0, 0); cyc(BEQ, 1, 1, 8, 0, 1);
      cyc(J, 1, 0, 0, 0, 0); cyc(J, 1, 0, 1, 0, 0); cyc(J, 1, 0, 9, 0, 1);
      // addi
      cyc(ADDI, 1, 0, 0, 0, 0); cyc(ADDI, 1, 0, 1, 0, 0);
      cyc(ADDI, 1, 0, 10, 0, 0); cyc(ADDI, 1, 0, 11, 0, 1);
      // illegal opcode: pulse in following FETCH, no retire
      cyc(ILL, 1, 0, 0, 0, 0); cyc(ILL, 1, 0, 1, 0, 0);
      cyc(R, 1, 0, 0, 1, 0); cyc(R, 1, 0, 1, 0, 0);
      cyc(R, 1, 0, 6, 0, 0); cyc(R, 1, 0, 7, 0, 1);
      // reset in MEM_WRITE while stalled
      cyc(SW, 1, 0, 0, 0, 0); cyc(SW, 1, 0, 1, 0, 0); cyc(SW, 1, 0, 2, 0, 0);
      opcode = SW; mem_ready = 1'b0;
      begin
         exp_t e;
         e.st = 4'd5; e.ctl = exp_ctl(4'd5, 1'b0, 1'b0); e.ret = exp_ret;
         q.push_back(e);
      end
      @(negedge clock); #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_state", {28'd0, state}, 32'd0);
      chk("mid_rst_mem_write", {31'd0, mem_write}, 32'd0);
      chk("mid_rst_retired", retired, 32'd0);
      chk("mid_rst_ctl", {15'd0, ctl_now}, 32'd0);
      exp_ret = 32'd0;
      @(posedge clock); @(posedge clock); #1;
      chk("held_rst_state", {28'd0, state}, 32'd0);
      reset_n = 1'b1;
      cyc(R, 1, 0, 0, 0, 0); cyc(R, 1, 0, 1, 0, 0);
      @(posedge clock); #1;
      chk("queue_drained", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
